// File: rtl/uart_host.sv
// uart_host: bus initiator that initialises the uart and moves bytes between its io registers and two FIFOs.
// Optional echo of received bytes into the tx FIFO is enabled with `define UART_HOST_ECHO_EN.
module uart_host #(
  parameter logic [11:0] DIV      = 12'd1,
  parameter logic [1:0]  INVERT   = 2'b00,
  parameter int          TXQ_LOG2 = 2,
  parameter int          RXQ_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [3:0] io_addr,
  output logic [7:0] io_wdata,
  output logic       io_write,
  output logic       io_read,
  input  logic [7:0] io_rdata,
  input  logic       uart_int,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       init_done
);

  localparam int TXD = 1 << TXQ_LOG2;
  localparam int RXD = 1 << RXQ_LOG2;

  typedef enum logic [3:0] {
    INIT0, INIT1, INIT2, INIT3, IDLE, STAT, RXRD, TXDONE, TXWR, TXCLR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_io_addr;
  logic [7:0]        r_io_wdata;
  logic              r_io_write;
  logic              r_io_read;
  logic              r_tx_inflight;
  logic              r_s_tx;
  logic              r_init_done;
  logic              r_rx_overrun;

  logic [7:0]        r_tx_mem [TXD];
  logic [TXQ_LOG2:0] r_tx_wp;
  logic [TXQ_LOG2:0] r_tx_rp;
  logic [7:0]        r_rx_mem [RXD];
  logic [RXQ_LOG2:0] r_rx_wp;
  logic [RXQ_LOG2:0] r_rx_rp;

  logic              w_tx_empty;
  logic              w_tx_full;
  logic              w_tx_push;
  logic              w_tx_ready;
  logic [7:0]        w_tx_din;
  logic [7:0]        w_tx_head;
  logic              w_rx_empty;
  logic              w_rx_full;
  logic              w_rx_push;
  logic              w_rx_pop;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[TXQ_LOG2] != r_tx_rp[TXQ_LOG2]) &&
                      (r_tx_wp[TXQ_LOG2-1:0] == r_tx_rp[TXQ_LOG2-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[RXQ_LOG2] != r_rx_rp[RXQ_LOG2]) &&
                      (r_rx_wp[RXQ_LOG2-1:0] == r_rx_rp[RXQ_LOG2-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rp[TXQ_LOG2-1:0]];

  always_comb begin
    w_rx_pop  = !w_rx_empty && rx_ready;
    w_rx_push = (r_state == RXRD) && (!w_rx_full || w_rx_pop);
`ifdef UART_HOST_ECHO_EN
    // An accepted rx byte owns the tx FIFO write port for that cycle.
    w_tx_ready = !w_tx_full && !w_rx_push;
    w_tx_push  = (w_rx_push && !w_tx_full) || (tx_valid && w_tx_ready);
    w_tx_din   = w_rx_push ? io_rdata : tx_data;
`else
    w_tx_ready = !w_tx_full;
    w_tx_push  = tx_valid && w_tx_ready;
    w_tx_din   = tx_data;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      // INIT0 holds one extra cycle after reset so its write is issued from a registered strobe.
      INIT0:   if (r_io_write) w_next = INIT1;
      INIT1:   w_next = INIT2;
      INIT2:   w_next = INIT3;
      INIT3:   w_next = IDLE;
      IDLE: begin
        if (uart_int)                          w_next = STAT;
        else if (!r_tx_inflight && !w_tx_empty) w_next = TXWR;
      end
      STAT:    w_next = io_rdata[1] ? RXRD : (io_rdata[0] ? TXDONE : IDLE);
      RXRD:    w_next = r_s_tx ? TXDONE : IDLE;
      TXDONE:  w_next = w_tx_empty ? TXCLR : TXWR;
      TXWR:    w_next = IDLE;
      TXCLR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= INIT0;
      r_io_addr     <= 4'd0;
      r_io_wdata    <= 8'h00;
      r_io_write    <= 1'b0;
      r_io_read     <= 1'b0;
      r_tx_inflight <= 1'b0;
      r_s_tx        <= 1'b0;
      r_init_done   <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_wp       <= '0;
      r_tx_rp       <= '0;
      r_rx_wp       <= '0;
      r_rx_rp       <= '0;
    end else begin
      r_state    <= w_next;
      r_io_write <= 1'b0;
      r_io_read  <= 1'b0;
      r_io_addr  <= 4'd0;
      r_io_wdata <= 8'h00;
      case (w_next)
        INIT0:   begin r_io_write <= 1'b1; r_io_addr <= 4'd4; r_io_wdata <= DIV[7:0]; end
        INIT1:   begin r_io_write <= 1'b1; r_io_addr <= 4'd5; r_io_wdata <= {4'b0, DIV[11:8]}; end
        INIT2:   begin r_io_write <= 1'b1; r_io_addr <= 4'd3; r_io_wdata <= {6'b0, INVERT}; end
        INIT3:   begin r_io_write <= 1'b1; r_io_addr <= 4'd2; r_io_wdata <= 8'h03; end
        STAT:    begin r_io_read  <= 1'b1; r_io_addr <= 4'd2; end
        RXRD:    begin r_io_read  <= 1'b1; r_io_addr <= 4'd0; end
        TXWR:    begin r_io_write <= 1'b1; r_io_addr <= 4'd1; r_io_wdata <= w_tx_head; end
        TXCLR:   begin r_io_write <= 1'b1; r_io_addr <= 4'd2; r_io_wdata <= 8'h01; end
        default: begin end
      endcase

      if (r_state == STAT) begin
        r_s_tx <= io_rdata[0];
        if (io_rdata[0]) r_tx_inflight <= 1'b0;
      end
      if (r_state == TXWR)               r_tx_inflight <= 1'b1;
      if (r_state == INIT3)              r_init_done   <= 1'b1;
      if ((r_state == RXRD) && !w_rx_push) r_rx_overrun <= 1'b1;

      if (w_tx_push)          r_tx_wp <= r_tx_wp + 1'b1;
      if (r_state == TXWR)    r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push)          r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)           r_rx_rp <= r_rx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TXQ_LOG2-1:0]] <= w_tx_din;
    if (w_rx_push) r_rx_mem[r_rx_wp[RXQ_LOG2-1:0]] <= io_rdata;
  end

  assign io_addr    = r_io_addr;
  assign io_wdata   = r_io_wdata;
  assign io_write   = r_io_write;
  assign io_read    = r_io_read;
  assign tx_ready   = w_tx_ready;
  assign rx_data    = r_rx_mem[r_rx_rp[RXQ_LOG2-1:0]];
  assign rx_valid   = !w_rx_empty;
  assign rx_overrun = r_rx_overrun;
  assign init_done  = r_init_done;

endmodule

// File: tb/tb_uart_host.sv
// tb_uart_host: directed bench for uart_host with a small uart register model on the io bus.
// Echo expectations are compiled in when UART_HOST_ECHO_EN is defined.
module tb_uart_host;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] io_addr;
  logic [7:0] io_wdata;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_rdata;
  logic       uart_int;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       init_done;

  uart_host #(.DIV(12'h2A5), .INVERT(2'b10), .TXQ_LOG2(2), .RXQ_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_write(io_write), .io_read(io_read),
    .io_rdata(io_rdata), .uart_int(uart_int),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Uart model: status bit1=rx int, bit0=tx int; reading addr 0 or writing addr 1 / W1C addr 2 clears.
  logic       rxInt = 1'b0;
  logic       txInt = 1'b0;
  logic       setRx = 1'b0;
  logic       setTx = 1'b0;
  logic [7:0] uRxByte = 8'h00;
  always @(posedge clk) begin
    if (io_read && io_addr == 4'd0) rxInt <= 1'b0;
    if (io_write && io_addr == 4'd1) txInt <= 1'b0;
    if (io_write && io_addr == 4'd2) begin
      if (io_wdata[1]) rxInt <= 1'b0;
      if (io_wdata[0]) txInt <= 1'b0;
    end
    if (setRx) rxInt <= 1'b1;
    if (setTx) txInt <= 1'b1;
  end
  assign uart_int = rxInt | txInt;
  assign io_rdata = (io_addr == 4'd2) ? {6'b0, rxInt, txInt} :
                    (io_addr == 4'd0) ? uRxByte : 8'h00;

  typedef struct {logic wr; logic [3:0] addr; logic [7:0] data; int cyc;} busOp_t;
  busOp_t opLog[$];
  busOp_t monOp;
  always @(negedge clk) begin
    if (io_write || io_read) begin
      monOp.wr   = io_write;
      monOp.addr = io_addr;
      monOp.data = io_write ? io_wdata : io_rdata;
      monOp.cyc  = cyc;
      opLog.push_back(monOp);
    end
  end

  typedef struct {logic [3:0] addr; logic [7:0] data;} initVec_t;
  typedef struct {logic [7:0] rxByte; logic expValid; logic expOverrun;} rxVec_t;
  initVec_t initTab[4];
  rxVec_t   ovfTab[5];

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic checkOp(input string nm, input int idx, input logic wr, input logic [3:0] a,
                         input logic [7:0] d);
    if (idx >= opLog.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no bus op seen, expected wr=%0d addr=%0d data=0x%0h", nm, wr, a, d);
    end else begin
      checkOutput(nm, {19'b0, opLog[idx].wr, opLog[idx].addr, opLog[idx].data}, {19'b0, wr, a, d});
    end
  endtask

  task automatic applyStimulus(input logic rx, input logic tx, input logic [7:0] b);
    @(negedge clk);
    uRxByte = b;
    setRx = rx;
    setTx = tx;
    @(negedge clk);
    setRx = 1'b0;
    setTx = 1'b0;
  endtask

  task automatic pushTx(input logic [7:0] b, output int pc);
    tx_data = b;
    tx_valid = 1'b1;
    pc = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic popRx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic waitInitDone();
    int n = 0;
    while (!init_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("initDoneSeen", {31'b0, init_done}, 32'd1);
  endtask

  task automatic checkInit(input int b);
    for (int i = 0; i < 4; i++)
      checkOp($sformatf("init%0d", i), b + i, 1'b1, initTab[i].addr, initTab[i].data);
    if (opLog.size() >= b + 4) begin
      checkOutput("initBackToBack", opLog[b+3].cyc - opLog[b].cyc, 32'd3);
      checkOutput("initDoneLatency", cyc - opLog[b+3].cyc, 32'd1);
    end
  endtask

  int base;
  int pc;
  int n;

  initial begin
    reset_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    rx_ready = 1'b0;
    initTab[0] = '{4'd4, 8'hA5};
    initTab[1] = '{4'd5, 8'h02};
    initTab[2] = '{4'd3, 8'h02};
    initTab[3] = '{4'd2, 8'h03};
    for (int i = 0; i < 5; i++) ovfTab[i] = '{8'(i + 1), 1'b1, (i == 4)};

    repeat (3) @(negedge clk);
    checkOutput("rstWrite", {31'b0, io_write}, 32'd0);
    checkOutput("rstRead", {31'b0, io_read}, 32'd0);
    checkOutput("rstAddr", {28'b0, io_addr}, 32'd0);
    checkOutput("rstWdata", {24'b0, io_wdata}, 32'd0);
    checkOutput("rstInitDone", {31'b0, init_done}, 32'd0);
    checkOutput("rstRxValid", {31'b0, rx_valid}, 32'd0);
    checkOutput("rstTxReady", {31'b0, tx_ready}, 32'd1);

    base = opLog.size();
    reset_n = 1'b1;
    waitInitDone();
    checkInit(base);

`ifndef UART_HOST_ECHO_EN
    // First tx byte goes straight out; the second waits for the tx interrupt.
    base = opLog.size();
    pushTx(8'h55, pc);
    repeat (4) @(negedge clk);
    checkOp("tx55", base, 1'b1, 4'd1, 8'h55);
    if (opLog.size() > base) checkOutput("tx55Latency", opLog[base].cyc - pc, 32'd2);
    pushTx(8'hAA, pc);
    repeat (6) @(negedge clk);
    checkOutput("txAAHeld", opLog.size() - base, 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    repeat (6) @(negedge clk);
    checkOp("txStat", base + 1, 1'b0, 4'd2, 8'h01);
    checkOp("txAA", base + 2, 1'b1, 4'd1, 8'hAA);
    checkOutput("txOpCount", opLog.size() - base, 32'd3);

    base = opLog.size();
    applyStimulus(1'b1, 1'b0, 8'h3C);
    repeat (6) @(negedge clk);
    checkOp("rxStat", base, 1'b0, 4'd2, 8'h02);
    checkOp("rxRead", base + 1, 1'b0, 4'd0, 8'h3C);
    checkOutput("rxNoWrite", opLog.size() - base, 32'd2);
    checkOutput("rxValid", {31'b0, rx_valid}, 32'd1);
    checkOutput("rxData", {24'b0, rx_data}, 32'h3C);
    popRx();
    checkOutput("rxPopped", {31'b0, rx_valid}, 32'd0);

    base = opLog.size();
    applyStimulus(1'b1, 1'b1, 8'h77);
    repeat (8) @(negedge clk);
    checkOp("s03Stat", base, 1'b0, 4'd2, 8'h03);
    checkOp("s03Read", base + 1, 1'b0, 4'd0, 8'h77);
    checkOp("s03Clear", base + 2, 1'b1, 4'd2, 8'h01);
    checkOutput("s03OpCount", opLog.size() - base, 32'd3);
    checkOutput("s03RxData", {24'b0, rx_data}, 32'h77);
    pushTx(8'h11, pc);
    repeat (4) @(negedge clk);
    checkOp("tx11AfterClear", base + 3, 1'b1, 4'd1, 8'h11);
    if (opLog.size() > base + 3) checkOutput("tx11Latency", opLog[base+3].cyc - pc, 32'd2);
    popRx();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, ovfTab[i].rxByte);
      repeat (6) @(negedge clk);
      checkOutput($sformatf("ovfValid%0d", i), {31'b0, rx_valid}, {31'b0, ovfTab[i].expValid});
      checkOutput($sformatf("ovfFlag%0d", i), {31'b0, rx_overrun}, {31'b0, ovfTab[i].expOverrun});
    end
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("drain%0d", k), {24'b0, rx_data}, 32'(k + 1));
      popRx();
    end
    repeat (2) @(negedge clk);
    checkOutput("drainEmpty", {31'b0, rx_valid}, 32'd0);
    checkOutput("overrunSticky", {31'b0, rx_overrun}, 32'd1);
`endif

    // Reset in the middle of the rx data read.
    applyStimulus(1'b1, 1'b0, 8'h99);
    n = 0;
    while (!(io_read && io_addr == 4'd0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachRxRead", {31'b0, (io_read && io_addr == 4'd0)}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstRead", {31'b0, io_read}, 32'd0);
    checkOutput("midRstAddr", {28'b0, io_addr}, 32'd0);
    checkOutput("midRstRxValid", {31'b0, rx_valid}, 32'd0);
    checkOutput("midRstOverrun", {31'b0, rx_overrun}, 32'd0);
    checkOutput("midRstInitDone", {31'b0, init_done}, 32'd0);
    checkOutput("midRstTxReady", {31'b0, tx_ready}, 32'd1);
    repeat (2) @(negedge clk);
    base = opLog.size();
    reset_n = 1'b1;
    waitInitDone();
    checkInit(base);
    repeat (5) @(negedge clk);
    checkOutput("reinitOpCount", opLog.size() - base, 32'd4);

`ifdef UART_HOST_ECHO_EN
    base = opLog.size();
    applyStimulus(1'b1, 1'b0, 8'h7E);
    repeat (8) @(negedge clk);
    checkOp("echoStat", base, 1'b0, 4'd2, 8'h02);
    checkOp("echoRead", base + 1, 1'b0, 4'd0, 8'h7E);
    checkOp("echoWrite", base + 2, 1'b1, 4'd1, 8'h7E);
    checkOutput("echoRxValid", {31'b0, rx_valid}, 32'd1);
    checkOutput("echoRxData", {24'b0, rx_data}, 32'h7E);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_host.md
Name: uart_host

Overview:
- Bus initiator that drives the 8-bit io register interface of the uart peripheral, the other end of the io_addr/io_wdata/io_write/io_read/io_rdata bus.
- After reset it programs the divisor and inversion, then services the uart interrupt.
- Received bytes go to an rx FIFO and queued bytes are sent from a tx FIFO.
- Lets a datapath block exchange a byte stream with the uart through valid/ready handshakes, with no CPU involvement.

Parameters:
- DIV, 1, 12-bit baud divisor written to uart regs 4/5 during init
- INVERT, 0, 2-bit value written to uart reg 3 ({rx_invert, tx_invert})
- TXQ_LOG2, 2, log2 tx FIFO depth (depth 4)
- RXQ_LOG2, 2, log2 rx FIFO depth (depth 4)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- io_addr  out  4  uart register address
- io_wdata  out  8  uart write data
- io_write  out  1  one-cycle write strobe
- io_read  out  1  one-cycle read strobe
- io_rdata  in  8  uart read data, combinational from io_addr
- uart_int  in  1  uart interrupt (rx_int|tx_int)
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx byte offered
- tx_ready  out  1  tx FIFO not full
- rx_data  out  8  head of rx FIFO
- rx_valid  out  1  rx FIFO not empty
- rx_ready  in  1  consumer pops rx head
- rx_overrun  out  1  sticky: received byte dropped, rx FIFO full
- init_done  out  1  init sequence complete

Behaviour:
- Reset (asynchronous, immediate on reset_n low):
  - state=INIT0, both FIFOs empty, tx_inflight=0, rx_overrun=0, init_done=0.
  - io_write=io_read=0, io_addr=0, io_wdata=0.
  - Reset mid-operation abandons any bus op; the uart sees no partial strobe.
- Bus rules:
  - io_* outputs are decoded from the registered state only.
  - At most one of io_write/io_read high per cycle, each for exactly 1 cycle per state visit.
  - io_rdata is sampled on the clock edge ending the io_read cycle.
- Init, one cycle each, all writes:
  - INIT0: addr 4 = DIV[7:0]
  - INIT1: addr 5 = {4'b0, DIV[11:8]}
  - INIT2: addr 3 = {6'b0, INVERT}
  - INIT3: addr 2 = 8'h03 (clears both ints)
  - then IDLE with init_done=1, held until reset.
- IDLE, checked in priority order:
  - uart_int=1 -> STAT.
  - else tx_inflight=0 and tx FIFO non-empty -> TXWR.
  - else stay in IDLE.
- STAT:
  - io_read addr 2; latch status bits s_rx=io_rdata[1], s_tx=io_rdata[0].
  - If s_tx: clear tx_inflight.
  - Next state: s_rx -> RXRD; else s_tx -> TXDONE; else IDLE.
- RXRD:
  - io_read addr 0; this read clears the uart rx int.
  - Push io_rdata to rx FIFO if count<depth or rx pop this cycle; otherwise drop and set rx_overrun.
  - Next state: s_tx -> TXDONE; else IDLE.
- TXDONE: tx FIFO non-empty -> TXWR; else TXCLR.
- TXWR:
  - io_write addr 1, io_wdata = tx FIFO head; this write also clears the uart tx int.
  - Pop tx FIFO, set tx_inflight=1 -> IDLE.
- TXCLR:
  - io_write addr 2 data 8'h01 -> IDLE.
  - Bit1 must never be written outside init, so a pending rx int is never lost.
- Only one tx byte is in flight: addr 1 is never written while tx_inflight=1.
- Handshakes:
  - tx push when tx_valid&tx_ready; tx_ready = !tx_full.
  - rx pop when rx_valid&rx_ready.
  - FIFO pointers are TXQ_LOG2/RXQ_LOG2+1 bits and wrap modulo 2*depth; full/empty are derived from the MSB compare.
- rx_overrun clears only on reset.
- Latency:
  - rx byte visible on rx_valid 3 cycles after uart_int rises from IDLE (IDLE, STAT, RXRD).
  - tx byte to io_write 2 cycles after push when idle (push, IDLE, TXWR).

Optional Feature:
- Macro UART_HOST_ECHO_EN.
- Defined: every byte accepted in RXRD is also pushed to the tx FIFO if not full. That cycle the echo push takes precedence, tx_ready is forced 0, and if the tx FIFO is full the echo copy is silently dropped (rx_overrun unaffected).
- Undefined: no echo path; tx FIFO fed only by tx_data.

Test Plan:
- Release reset_n, DIV=12'h2A5, INVERT=2'b10 -> 4 consecutive writes (4,8'hA5),(5,8'h02),(3,8'h02),(2,8'h03), then init_done=1.
- Push 8'h55 at IDLE -> TXWR writes addr 1 data 8'h55 two cycles later; second push 8'hAA is held (no addr-1 write) until uart_int with status 8'h01, then addr 1 8'hAA is written.
- uart_int with status 8'h02, addr 0 returns 8'h3C -> read addr 2, then read addr 0; rx_valid=1, rx_data=8'h3C; no write to addr 2 occurs.
- Status 8'h03 with tx FIFO empty -> read 2, read 0, write addr 2 data 8'h01; tx_inflight=0.
- rx_ready=0, 5 received bytes 8'h01..8'h05 -> first 4 queued in order, byte 8'h05 dropped, rx_overrun=1 until reset.
- Assert reset_n=0 during RXRD -> io_read falls immediately, FIFOs empty, init sequence restarts after release; with UART_HOST_ECHO_EN defined, received 8'h7E produces a write of addr 1 data 8'h7E.
